// File: rtl/wb_cmd_master.sv
// Command-to-Wishbone bridge: turns one command into one single-beat classic
// Wishbone cycle and returns a response carrying read data, bus error or timeout.
module wb_cmd_master #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 256
) (
   input  logic            clk_i,
   input  logic            rst_i,
   // command channel
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [DW-1:0]   cmd_data,
   input  logic [DW/8-1:0] cmd_sel,
   // response channel
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_data,
   output logic            rsp_err,
   output logic            rsp_timeout,
   // wishbone initiator
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic            wb_we_o,
   output logic [AW-1:0]   wb_addr_o,
   output logic [DW-1:0]   wb_data_o,
   output logic [DW/8-1:0] wb_sel_o,
   input  logic [DW-1:0]   wb_data_i,
   input  logic            wb_ack_i,
   input  logic            wb_err_i
);

   localparam int CW = 16;
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt;
   logic          accept, hit_ack, hit_err, hit_to, bus_end, rsp_hs;

   assign cmd_ready = (state == IDLE);

   always_comb begin
      accept    = 1'b0;
      hit_ack   = 1'b0;
      hit_err   = 1'b0;
      hit_to    = 1'b0;
      rsp_hs    = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            accept = cmd_valid;
            if (cmd_valid) state_nxt = BUS;
         end
         BUS: begin
            // err outranks ack, and either outranks a timeout landing in the same cycle
            hit_err = wb_err_i;
            hit_ack = wb_ack_i && !wb_err_i;
            hit_to  = !wb_ack_i && !wb_err_i && (wait_cnt == WAIT_LAST);
            if (hit_err || hit_ack || hit_to) state_nxt = RESP;
         end
         RESP: begin
            rsp_hs = rsp_ready;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus_end = hit_ack || hit_err || hit_to;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_cnt    <= '0;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_addr_o   <= '0;
         wb_data_o   <= '0;
         wb_sel_o    <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else if (accept) begin
         wait_cnt  <= '0;
         wb_cyc_o  <= 1'b1;
         wb_stb_o  <= 1'b1;
         wb_we_o   <= cmd_we;
         wb_addr_o <= cmd_addr;
         wb_data_o <= cmd_data;
         wb_sel_o  <= cmd_sel;
      end else if (bus_end) begin
         // bus side returns to idle values while the response is presented
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_addr_o   <= '0;
         wb_data_o   <= '0;
         wb_sel_o    <= '0;
         rsp_valid   <= 1'b1;
         rsp_err     <= hit_err || hit_to;
         rsp_timeout <= hit_to;
         rsp_data    <= (hit_ack && !wb_we_o) ? wb_data_i : '0;
      end else if (state == BUS) begin
         wait_cnt <= wait_cnt + CW'(1);
      end else if (rsp_hs) begin
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master: each transaction's expected bus length
// and response come from a transaction-level model of delay/kind/timeout.
module tb_wb_cmd_master;
   localparam int AW = 32, DW = 32, SW = DW/8, TO = 8;

   logic          clk_i = 1'b0, rst_i = 1'b1;
   logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic [SW-1:0] cmd_sel  = '0;
   logic          rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
   logic [DW-1:0] rsp_data;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [AW-1:0] wb_addr_o;
   logic [DW-1:0] wb_data_o;
   logic [SW-1:0] wb_sel_o;
   logic [DW-1:0] wb_data_i = '0;
   logic          wb_ack_i = 1'b0, wb_err_i = 1'b0;

   int n_tests = 0, n_fail = 0;

   wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
      .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic noise_cmd();
      cmd_valid = $urandom_range(0, 1);
      cmd_we    = $urandom_range(0, 1);
      cmd_addr  = $urandom;
      cmd_data  = $urandom;
      cmd_sel   = SW'($urandom);
   endtask

   // kind: 0 = no response, 1 = ack, 2 = err, 3 = ack+err; d = wait cycles before it
   task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [SW-1:0] sel, input int d, input logic [1:0] kind, input int bp);
      int            len;
      logic          resp, e_err, e_to;
      logic [DW-1:0] rdata, e_data;
      rdata  = $urandom;
      resp   = (kind != 2'd0) && (d + 1 <= TO);
      len    = resp ? d + 1 : TO;
      e_err  = resp ? kind[1] : 1'b1;
      e_to   = !resp;
      e_data = (resp && kind == 2'd1 && !we) ? rdata : '0;

      @(negedge clk_i);
      chk("idle_rdy", cmd_ready, 1);
      chk("idle_cyc", wb_cyc_o, 0);
      chk("idle_rsp", rsp_valid, 0);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_sel = sel;
      wb_ack_i = $urandom_range(0, 1); wb_err_i = $urandom_range(0, 1);

      for (int k = 1; k <= len; k++) begin
         @(negedge clk_i);
         chk("bus_cyc", wb_cyc_o, 1);
         chk("bus_stb", wb_stb_o, 1);
         chk("bus_we", wb_we_o, we);
         chk("bus_addr", wb_addr_o, addr);
         chk("bus_data", wb_data_o, data);
         chk("bus_sel", wb_sel_o, sel);
         chk("bus_rsp", rsp_valid, 0);
         chk("bus_rdy", cmd_ready, 0);
         noise_cmd();
         if (resp && k == d + 1) begin
            wb_ack_i = kind[0]; wb_err_i = kind[1]; wb_data_i = rdata;
         end else begin
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_data_i = $urandom;
         end
      end

      // response presented, then held under backpressure
      for (int b = 0; b <= bp; b++) begin
         @(negedge clk_i);
         chk("rsp_cyc", wb_cyc_o, 0);
         chk("rsp_stb", wb_stb_o, 0);
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_err", rsp_err, e_err);
         chk("rsp_to", rsp_timeout, e_to);
         chk("rsp_data", rsp_data, e_data);
         chk("rsp_rdy", cmd_ready, 0);
         noise_cmd();
         wb_ack_i = $urandom_range(0, 1); wb_err_i = $urandom_range(0, 1);
         rsp_ready = (b == bp);
      end
      cmd_valid = 1'b1;

      @(negedge clk_i);
      chk("post_valid", rsp_valid, 0);
      chk("post_rdy", cmd_ready, 1);
      chk("post_cyc", wb_cyc_o, 0);
      chk("post_err", rsp_err, 0);
      chk("post_data", rsp_data, 0);
      rsp_ready = 1'b0; cmd_valid = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
   endtask

   // abort a command by reset either in its second BUS cycle or while in RESP
   task automatic rst_abort(input logic in_resp);
      @(negedge clk_i);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = $urandom; cmd_sel = 4'hF;
      @(negedge clk_i);
      cmd_valid = 1'b0;
      wb_ack_i  = in_resp;
      @(negedge clk_i);
      wb_ack_i = 1'b0;
      if (in_resp) chk("ab_rspv", rsp_valid, 1);
      else         chk("ab_cyc2", wb_cyc_o, 1);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("ab_cyc", wb_cyc_o, 0);
      chk("ab_stb", wb_stb_o, 0);
      chk("ab_rsp", rsp_valid, 0);
      chk("ab_rdy", cmd_ready, 1);
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wb_ack_i = $urandom_range(0, 1);
         @(negedge clk_i);
         chk("ab_quiet_rsp", rsp_valid, 0);
         chk("ab_quiet_cyc", wb_cyc_o, 0);
         chk("ab_quiet_rdy", cmd_ready, 1);
      end
      wb_ack_i = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      chk("rst_rdy", cmd_ready, 1);
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_stb", wb_stb_o, 0);
      chk("rst_we", wb_we_o, 0);
      chk("rst_addr", wb_addr_o, 0);
      chk("rst_rspv", rsp_valid, 0);
      chk("rst_rspd", rsp_data, 0);
      chk("rst_err", rsp_err | rsp_timeout, 0);
      rst_i = 1'b0;

      txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 2'd1, 0);          // write, ack after 1
      txn(1'b0, 32'h10, 32'h0, 4'hF, 3, 2'd1, 0);                  // read, 3 waits
      txn(1'b0, 32'h24, 32'h0, 4'h3, 0, 2'd3, 0);                  // ack+err
      txn(1'b1, 32'h30, 32'h1234_5678, 4'h1, 0, 2'd0, 0);          // timeout
      txn(1'b0, 32'h40, 32'h0, 4'hF, 0, 2'd1, 0);                  // min latency
      txn(1'b0, 32'h44, 32'h0, 4'hF, TO - 1, 2'd1, 0);             // ack on timeout cycle
      txn(1'b1, 32'h48, 32'h5555_AAAA, 4'hC, TO - 1, 2'd2, 0);     // err on timeout cycle
      txn(1'b0, 32'h50, 32'h0, 4'hF, 2, 2'd1, 5);                  // backpressure
      rst_abort(1'b0);
      rst_abort(1'b1);

      for (int t = 0; t < 40; t++)
         txn(1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom),
             $urandom_range(0, TO + 2), 2'($urandom_range(0, 3)), $urandom_range(0, 3));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
